// File: rtl/brush_writer_pkg.sv
// Shared definitions for the brush writer slice.
// - Colour codes written into the framebuffer (decoded to RGB by the VGA scan path)
//   and the in_palette() validity check.
// - Framebuffer geometry defaults (H_RES, V_RES, ADDR_W) and the largest brush size.
// - Command field widths, the clipped-rectangle struct and the writer state enum.
// Optional feature macro: CLEAR_SCREEN_EN adds the CLEAR state.
package brush_writer_pkg;

    // Framebuffer geometry defaults
    localparam int unsigned H_RES_DEF    = 160;
    localparam int unsigned V_RES_DEF    = 120;
    localparam int unsigned ADDR_W_DEF   = 15;
    localparam int unsigned MAX_SIZE_DEF = 3;

    // Command field widths
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned SIZE_W  = 2;

    typedef logic [COLOR_W-1:0] color_t;

    // Colour codes; 3'd7 is deliberately left undefined
    localparam color_t COL_ERASE  = 3'd0;
    localparam color_t COL_RED    = 3'd1;
    localparam color_t COL_GREEN  = 3'd2;
    localparam color_t COL_BLUE   = 3'd3;
    localparam color_t COL_YELLOW = 3'd4;
    localparam color_t COL_PURPLE = 3'd5;
    localparam color_t COL_WHITE  = 3'd6;

    function automatic logic in_palette(color_t code);
        case (code)
            COL_ERASE, COL_RED, COL_GREEN, COL_BLUE,
            COL_YELLOW, COL_PURPLE, COL_WHITE: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Inclusive clipped rectangle of a brush stroke
    typedef struct packed {
        logic [X_W-1:0] x0;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y0;
        logic [Y_W-1:0] y1;
    } clip_t;

    typedef enum logic [1:0] {
        IDLE,
        PAINT
`ifdef CLEAR_SCREEN_EN
        , CLEAR
`endif
    } state_t;

endpackage

// File: rtl/brush_writer_if.sv
// Brush command handshake bundle.
// - cmd_valid/cmd_ready: valid/ready handshake
// - cmd_x/cmd_y: brush centre, cmd_color: colour code, cmd_size: half-width
// - clear_req: full-screen erase request (only with CLEAR_SCREEN_EN)
// master = command source, slave = brush_writer.
interface brush_writer_if;
    import brush_writer_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [X_W-1:0]      cmd_x;
    logic [Y_W-1:0]      cmd_y;
    color_t              cmd_color;
    logic [SIZE_W-1:0]   cmd_size;
`ifdef CLEAR_SCREEN_EN
    logic                clear_req;
`endif

    modport master (
`ifdef CLEAR_SCREEN_EN
        output clear_req,
`endif
        output cmd_valid, cmd_x, cmd_y, cmd_color, cmd_size,
        input  cmd_ready
    );

    modport slave (
`ifdef CLEAR_SCREEN_EN
        input  clear_req,
`endif
        input  cmd_valid, cmd_x, cmd_y, cmd_color, cmd_size,
        output cmd_ready
    );

endinterface

// File: rtl/brush_writer_clip.sv
// brush_clip: combinational clip of a brush square against the framebuffer and
// the decision to drop an unpaintable command.
// Ports: x_i/y_i centre, size_i half-width, color_i code -> clip_o rectangle, drop_o.
module brush_clip
    import brush_writer_pkg::*;
#(
    parameter int unsigned H_RES    = H_RES_DEF,
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned MAX_SIZE = MAX_SIZE_DEF
) (
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic [SIZE_W-1:0] size_i,
    input  color_t            color_i,
    output clip_t             clip_o,
    output logic              drop_o
);

    // Two guard bits so centre-size cannot wrap and centre+size cannot overflow
    logic signed [X_W+1:0] x_lo;
    logic        [X_W+1:0] x_hi;
    logic signed [Y_W+1:0] y_lo;
    logic        [Y_W+1:0] y_hi;

    always_comb begin
        clip_o = '0;
        drop_o = 1'b0;

        x_lo = $signed({2'b00, x_i}) - $signed({{X_W{1'b0}}, size_i});
        x_hi = {2'b00, x_i} + {{X_W{1'b0}}, size_i};
        y_lo = $signed({2'b00, y_i}) - $signed({{Y_W{1'b0}}, size_i});
        y_hi = {2'b00, y_i} + {{Y_W{1'b0}}, size_i};

        clip_o.x0 = x_lo[X_W+1] ? '0 : X_W'(x_lo);
        clip_o.x1 = (x_hi > (X_W+2)'(H_RES - 1)) ? X_W'(H_RES - 1) : X_W'(x_hi);
        clip_o.y0 = y_lo[Y_W+1] ? '0 : Y_W'(y_lo);
        clip_o.y1 = (y_hi > (Y_W+2)'(V_RES - 1)) ? Y_W'(V_RES - 1) : Y_W'(y_hi);

        drop_o = ({2'b00, x_i} >= (X_W+2)'(H_RES)) ||
                 ({2'b00, y_i} >= (Y_W+2)'(V_RES)) ||
                 (32'(size_i) > MAX_SIZE)           ||
                 !in_palette(color_i);
    end

endmodule

// File: rtl/brush_writer.sv
// brush_writer: rasterises brush-stroke commands into clipped squares and issues
// one framebuffer write per clock in raster order.
// Ports:
// - clk, reset      : clock, synchronous active-high reset
// - bus (slave)     : command handshake (brush_writer_if)
// - fb_we/fb_waddr/fb_wdata : registered framebuffer write port
// - busy            : high while painting or clearing
// Optional feature macro: CLEAR_SCREEN_EN (full-screen erase via bus.clear_req).
module brush_writer
    import brush_writer_pkg::*;
#(
    parameter int unsigned H_RES    = H_RES_DEF,
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned MAX_SIZE = MAX_SIZE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    brush_writer_if.slave     bus,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output color_t            fb_wdata,
    output logic              busy
);

    state_t            state_q;
    logic [X_W-1:0]    x_q, x0_q, x1_q;
    logic [Y_W-1:0]    y_q, y1_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_waddr_q;
    color_t            fb_wdata_q;
    logic              busy_q;

    clip_t             clip_c;
    logic              drop_c;
    logic              accept_c;
    logic [ADDR_W-1:0] row_base_init_c;

    brush_clip #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .MAX_SIZE (MAX_SIZE)
    ) u_clip (
        .x_i     (bus.cmd_x),
        .y_i     (bus.cmd_y),
        .size_i  (bus.cmd_size),
        .color_i (bus.cmd_color),
        .clip_o  (clip_c),
        .drop_o  (drop_c)
    );

    // Ready only in IDLE outside reset; a pending clear takes priority over commands
    always_comb begin
        bus.cmd_ready = (state_q == IDLE) && !reset;
`ifdef CLEAR_SCREEN_EN
        if (bus.clear_req) begin
            bus.cmd_ready = 1'b0;
        end
`endif
    end

    assign accept_c        = bus.cmd_valid && bus.cmd_ready;
    // Only multiply in the design: one row-base per accepted command
    assign row_base_init_c = ADDR_W'(32'(clip_c.y0) * H_RES);

    // Writer FSM with registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y_q        <= '0;
            y1_q       <= '0;
            row_base_q <= '0;
            fb_we_q    <= 1'b0;
            fb_waddr_q <= '0;
            fb_wdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    fb_we_q <= 1'b0;
`ifdef CLEAR_SCREEN_EN
                    if (bus.clear_req) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        fb_we_q    <= 1'b1;
                        fb_waddr_q <= '0;
                        fb_wdata_q <= COL_ERASE;
                    end else
`endif
                    if (accept_c && !drop_c) begin
                        state_q    <= PAINT;
                        busy_q     <= 1'b1;
                        x_q        <= clip_c.x0;
                        x0_q       <= clip_c.x0;
                        x1_q       <= clip_c.x1;
                        y_q        <= clip_c.y0;
                        y1_q       <= clip_c.y1;
                        row_base_q <= row_base_init_c;
                        fb_we_q    <= 1'b1;
                        fb_waddr_q <= row_base_init_c + ADDR_W'(clip_c.x0);
                        fb_wdata_q <= bus.cmd_color;
                    end
                end

                // (x_q, y_q) is the pixel currently presented on the write port
                PAINT: begin
                    if (x_q == x1_q && y_q == y1_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        fb_we_q <= 1'b0;
                    end else if (x_q == x1_q) begin
                        x_q        <= x0_q;
                        y_q        <= y_q + Y_W'(1);
                        row_base_q <= row_base_q + ADDR_W'(H_RES);
                        fb_waddr_q <= row_base_q + ADDR_W'(H_RES) + ADDR_W'(x0_q);
                    end else begin
                        x_q        <= x_q + X_W'(1);
                        fb_waddr_q <= row_base_q + ADDR_W'(x_q + X_W'(1));
                    end
                end

`ifdef CLEAR_SCREEN_EN
                CLEAR: begin
                    if (fb_waddr_q == ADDR_W'(H_RES * V_RES - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        fb_we_q <= 1'b0;
                    end else begin
                        fb_waddr_q <= fb_waddr_q + ADDR_W'(1);
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_waddr = fb_waddr_q;
    assign fb_wdata = fb_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_brush_writer.sv
// Self-checking bench for brush_writer: directed scenarios plus random commands
// checked against a pixel-list model of the clipped brush square.
// Exercises the clear feature when compiled with CLEAR_SCREEN_EN.
module tb_brush_writer;
    import brush_writer_pkg::*;

    localparam int HR = 160;
    localparam int VR = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fb_we;
    logic [14:0] fb_waddr;
    color_t      fb_wdata;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    brush_writer_if bif();

    brush_writer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif.slave),
        .fb_we    (fb_we),
        .fb_waddr (fb_waddr),
        .fb_wdata (fb_wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit code_defined(int c);
        return c == int'(COL_RED)    || c == int'(COL_GREEN)  || c == int'(COL_BLUE) ||
               c == int'(COL_YELLOW) || c == int'(COL_PURPLE) || c == int'(COL_WHITE) ||
               c == int'(COL_ERASE);
    endfunction

    // Expected write addresses: every pixel of the square inside the screen, raster order
    task automatic model(input int x, input int y, input int c, input int s);
        exp_q.delete();
        if (x >= HR || y >= VR || s > 3 || !code_defined(c)) return;
        for (int yy = y - s; yy <= y + s; yy++) begin
            for (int xx = x - s; xx <= x + s; xx++) begin
                if (xx >= 0 && xx < HR && yy >= 0 && yy < VR) exp_q.push_back(yy * HR + xx);
            end
        end
    endtask

    task automatic drive(input int x, input int y, input int c, input int s);
        bif.cmd_x     = 8'(x);
        bif.cmd_y     = 7'(y);
        bif.cmd_color = 3'(c);
        bif.cmd_size  = 2'(s);
    endtask

    // Called at the negedge after acceptance; consumes the write burst
    task automatic collect(input color_t col, input int budget, input string name);
        int n = 0;
        int cyc = 0;
        logic [14:0] ea;
        while (fb_we === 1'b1 && cyc < budget) begin
            tests++;
            if (n >= exp_q.size()) begin
                fails++;
                $display("FAIL %s extra write #%0d addr=%0d", name, n, fb_waddr);
            end else begin
                ea = 15'(exp_q[n]);
                if (fb_waddr !== ea || fb_wdata !== col || busy !== 1'b1 || bif.cmd_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s write #%0d addr=%0d data=%0d busy=%b rdy=%b, want addr=%0d data=%0d busy=1 rdy=0",
                             name, n, fb_waddr, fb_wdata, busy, bif.cmd_ready, ea, col);
                end
            end
            n++;
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (n != exp_q.size()) begin
            fails++;
            $display("FAIL %s write count %0d, want %0d", name, n, exp_q.size());
        end
        tests++;
        if (bif.cmd_ready !== 1'b1 || busy !== 1'b0 || fb_we !== 1'b0) begin
            fails++;
            $display("FAIL %s after burst rdy=%b busy=%b we=%b, want 1 0 0", name, bif.cmd_ready, busy, fb_we);
        end
    endtask

    task automatic send_and_check(input int x, input int y, input int c, input int s, input string name);
        @(negedge clk);
        drive(x, y, c, s);
        bif.cmd_valid = 1'b1;
        tests++;
        if (bif.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready at offer=%b, want 1", name, bif.cmd_ready);
        end
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        model(x, y, c, s);
        collect(3'(c), 100, name);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (fb_we !== 1'b0 || fb_waddr !== 15'd0 || fb_wdata !== 3'd0 || busy !== 1'b0 || bif.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state we=%b addr=%0d data=%0d busy=%b rdy=%b, want all 0",
                     fb_we, fb_waddr, fb_wdata, busy, bif.cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bif.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release rdy=%b, want 1", bif.cmd_ready);
        end
    endtask

    task automatic test_paint();
        send_and_check(10, 20, COL_RED, 0, "single_pixel");
        send_and_check(50, 50, COL_GREEN, 1, "square_s1");
    endtask

    task automatic test_corners();
        send_and_check(0, 0, COL_BLUE, 2, "corner_tl");
        send_and_check(159, 119, COL_YELLOW, 1, "corner_br");
        send_and_check(80, 0, COL_WHITE, 3, "edge_top");
    endtask

    task automatic test_drops();
        send_and_check(160, 10, COL_RED, 1, "drop_x");
        send_and_check(10, 120, COL_RED, 1, "drop_y");
        send_and_check(40, 40, 7, 1, "drop_color");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(70, 40, COL_PURPLE, 1);
        bif.cmd_valid = 1'b1;
        @(negedge clk);
        drive(71, 60, COL_YELLOW, 0);
        model(70, 40, COL_PURPLE, 1);
        collect(COL_PURPLE, 100, "b2b_first");
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        model(71, 60, COL_YELLOW, 0);
        collect(COL_YELLOW, 100, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge clk);
        drive(30, 30, COL_BLUE, 1);
        bif.cmd_valid = 1'b1;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (fb_we === 1'b1) n++;
            if (n == 4) break;
            @(negedge clk);
        end
        tests++;
        if (n != 4 || fb_waddr !== 15'(30 * HR + 29)) begin
            fails++;
            $display("FAIL mid_fourth_write n=%0d addr=%0d, want 4 and %0d", n, fb_waddr, 30 * HR + 29);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (fb_we !== 1'b0 || busy !== 1'b0 || fb_waddr !== 15'd0 || bif.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset we=%b busy=%b addr=%0d rdy=%b, want 0 0 0 0",
                     fb_we, busy, fb_waddr, bif.cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (fb_we !== 1'b0) begin
            fails++;
            $display("FAIL mid_after_release we=%b, want 0", fb_we);
        end
        send_and_check(100, 100, COL_WHITE, 1, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            send_and_check($urandom_range(0, 170), $urandom_range(0, 127),
                           $urandom_range(0, 7), $urandom_range(0, 3), "random");
        end
    endtask

`ifdef CLEAR_SCREEN_EN
    task automatic test_clear();
        @(negedge clk);
        drive(5, 5, COL_RED, 0);
        bif.cmd_valid = 1'b1;
        bif.clear_req = 1'b1;
        tests++;
        if (bif.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_priority rdy=%b, want 0", bif.cmd_ready);
        end
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        bif.clear_req = 1'b0;
        exp_q.delete();
        for (int a = 0; a < HR * VR; a++) exp_q.push_back(a);
        collect(COL_ERASE, HR * VR + 10, "clear");
        @(negedge clk);
        tests++;
        if (fb_we !== 1'b0) begin
            fails++;
            $display("FAIL clear_no_cmd we=%b, want 0", fb_we);
        end
    endtask
`endif

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_x     = '0;
        bif.cmd_y     = '0;
        bif.cmd_color = '0;
        bif.cmd_size  = '0;
`ifdef CLEAR_SCREEN_EN
        bif.clear_req = 1'b0;
`endif
        test_reset();
        test_paint();
        test_corners();
        test_drops();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef CLEAR_SCREEN_EN
        test_clear();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
